// File: rtl/rr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_packet_arbiter
// Purpose  : NoC output-port arbiter with one round-robin arbiter per output,
//            wormhole locking until tail, and credit-aware flit transfer.
// Revision : 1.0
// ============================================================================
module rr_packet_arbiter #(
    parameter int NUM_PORTS = 5
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_PORTS*NUM_PORTS-1:0] req_i,
    input  logic [NUM_PORTS-1:0]           flit_v_i,
    input  logic [NUM_PORTS-1:0]           head_i,
    input  logic [NUM_PORTS-1:0]           tail_i,
    input  logic [NUM_PORTS-1:0]           out_rdy_i,
    output logic [NUM_PORTS*NUM_PORTS-1:0] grant_o,
    output logic [NUM_PORTS-1:0]           busy_o,
    output logic [NUM_PORTS-1:0]           fire_o
);

    localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    state_t                         r_state     [NUM_PORTS];
    logic   [PTR_W-1:0]             r_owner     [NUM_PORTS];
    logic   [PTR_W-1:0]             r_ptr       [NUM_PORTS];
    logic   [NUM_PORTS*NUM_PORTS-1:0] r_grant;

    state_t                         w_nxt_state [NUM_PORTS];
    logic   [PTR_W-1:0]             w_nxt_owner [NUM_PORTS];
    logic   [PTR_W-1:0]             w_nxt_ptr   [NUM_PORTS];
    logic   [NUM_PORTS*NUM_PORTS-1:0] w_nxt_grant;

    logic   [NUM_PORTS-1:0]           w_owns;
    logic   [NUM_PORTS-1:0]           w_seen;
    logic   [NUM_PORTS-1:0]           w_found;
    logic   [NUM_PORTS-1:0]           w_fire;
    logic   [NUM_PORTS*NUM_PORTS-1:0] w_req_first;
    logic   [NUM_PORTS*NUM_PORTS-1:0] w_cand;

    // An input that already holds any output may not compete for another.
    always_comb begin
        w_owns = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_owns[i] = w_owns[i] | r_grant[o*NUM_PORTS + i];
            end
        end
    end

    // Multi-hot requests are reduced to the lowest-index requested output.
    always_comb begin
        w_req_first = '0;
        w_seen      = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (req_i[o*NUM_PORTS + i] && !w_seen[i]) begin
                    w_req_first[o*NUM_PORTS + i] = 1'b1;
                    w_seen[i]                    = 1'b1;
                end
            end
        end
    end

    assign w_cand = w_req_first & {NUM_PORTS{flit_v_i & head_i & ~w_owns}};

    always_comb begin
        w_nxt_grant = r_grant;
        w_found     = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            w_nxt_state[o] = r_state[o];
            w_nxt_owner[o] = r_owner[o];
            w_nxt_ptr[o]   = r_ptr[o];
            case (r_state[o])
                S_IDLE: begin
                    w_nxt_grant[o*NUM_PORTS +: NUM_PORTS] = '0;
                    for (int k = 0; k < NUM_PORTS; k++) begin
                        if (!w_found[o] &&
                            w_cand[o*NUM_PORTS + ((int'(r_ptr[o]) + k) % NUM_PORTS)]) begin
                            w_found[o]     = 1'b1;
                            w_nxt_state[o] = S_LOCKED;
                            w_nxt_owner[o] = PTR_W'((int'(r_ptr[o]) + k) % NUM_PORTS);
                            w_nxt_grant[o*NUM_PORTS + ((int'(r_ptr[o]) + k) % NUM_PORTS)] = 1'b1;
                        end
                    end
                end
                S_LOCKED: begin
                    // Release only when the owner's tail flit actually transfers.
                    if (flit_v_i[r_owner[o]] && out_rdy_i[o] && tail_i[r_owner[o]]) begin
                        w_nxt_state[o] = S_IDLE;
                        w_nxt_grant[o*NUM_PORTS +: NUM_PORTS] = '0;
                        w_nxt_ptr[o] = (r_owner[o] == PTR_W'(NUM_PORTS - 1)) ?
                                       '0 : r_owner[o] + 1'b1;
                    end
                end
                default: begin
                    w_nxt_state[o] = S_IDLE;
                    w_nxt_grant[o*NUM_PORTS +: NUM_PORTS] = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_grant <= '0;
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_state[o] <= S_IDLE;
                r_owner[o] <= '0;
                r_ptr[o]   <= '0;
            end
        end else begin
            r_grant <= w_nxt_grant;
            for (int o = 0; o < NUM_PORTS; o++) begin
                r_state[o] <= w_nxt_state[o];
                r_owner[o] <= w_nxt_owner[o];
                r_ptr[o]   <= w_nxt_ptr[o];
            end
        end
    end

    always_comb begin
        w_fire = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                w_fire[i] = w_fire[i] |
                            (r_grant[o*NUM_PORTS + i] & flit_v_i[i] & out_rdy_i[o]);
            end
        end
    end

    generate
        for (genvar o = 0; o < NUM_PORTS; o++) begin : g_busy
            assign busy_o[o] = (r_state[o] == S_LOCKED);
        end
    endgenerate

    assign grant_o = r_grant;
    assign fire_o  = w_fire;

endmodule
`default_nettype wire

// File: tb/tb_rr_packet_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_packet_arbiter
// Purpose  : Directed scoreboard bench for rr_packet_arbiter (5 ports).
// Revision : 1.0
// ============================================================================
module tb_rr_packet_arbiter;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N*N-1:0] req_i;
    logic [N-1:0]   flit_v_i, head_i, tail_i, out_rdy_i;
    logic [N*N-1:0] grant_o;
    logic [N-1:0]   busy_o, fire_o;

    typedef struct packed {
        logic [N*N-1:0] g;
        logic [N-1:0]   b;
        logic [N-1:0]   f;
    } exp_t;

    exp_t           q[$];
    int             errors = 0;
    int             checks = 0;
    bit             probe  = 1'b0;
    bit             mon_en = 1'b0;
    logic [N*N-1:0] prev_g = '0;
    int             owners[6] = '{0, 1, 3, 0, 1, 3};

    rr_packet_arbiter #(.NUM_PORTS(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req_i),
        .flit_v_i  (flit_v_i),
        .head_i    (head_i),
        .tail_i    (tail_i),
        .out_rdy_i (out_rdy_i),
        .grant_o   (grant_o),
        .busy_o    (busy_o),
        .fire_o    (fire_o)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic [N*N-1:0] rq, input logic [N-1:0] fv,
                       input logic [N-1:0] hd, input logic [N-1:0] tl,
                       input logic [N-1:0] rdy);
        @(posedge clk);
        #1;
        req_i     = rq;
        flit_v_i  = fv;
        head_i    = hd;
        tail_i    = tl;
        out_rdy_i = rdy;
        probe     = 1'b0;
    endtask

    task automatic expect_ev(input logic [N*N-1:0] g, input logic [N-1:0] b,
                             input logic [N-1:0] f);
        q.push_back({g, b, f});
        probe = 1'b1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Monitor: consumes one expected record whenever the DUT shows an event.
    always @(negedge clk) begin
        if (mon_en) begin
            if (probe || (grant_o != prev_g) || (fire_o != '0)) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event at %0t: grant=%h busy=%h fire=%h",
                             $time, grant_o, busy_o, fire_o);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("grant", 32'(grant_o), 32'(e.g));
                    chk("busy",  32'(busy_o),  32'(e.b));
                    chk("fire",  32'(fire_o),  32'(e.f));
                end
            end
            prev_g = grant_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b0;
        req_i     = '0;
        flit_v_i  = '0;
        head_i    = '0;
        tail_i    = '0;
        out_rdy_i = '0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Reset held with random traffic: everything stays quiet
        repeat (2) begin
            cyc(25'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            expect_ev('0, '0, '0);
        end

        // Input 2 single-flit packet to output 0
        cyc(25'h4, 5'b00100, 5'b00100, 5'b00100, 5'h1F);
        rst = 1'b1;
        cyc(25'h4, 5'b00100, 5'b00100, 5'b00100, 5'h1F);
        expect_ev(25'h4, 5'h01, 5'h04);
        cyc('0, '0, '0, '0, 5'h1F);
        expect_ev('0, '0, '0);

        // Non-head flit from an un-granted input is ignored
        cyc(25'h8, 5'b01000, 5'b00000, 5'b00000, 5'h1F);
        cyc(25'h8, 5'b01000, 5'b00000, 5'b00000, 5'h1F);
        expect_ev('0, '0, '0);
        cyc('0, '0, '0, '0, 5'h1F);

        // Round robin: inputs 0,1,3 to output 4, single-flit packets
        for (int k = 0; k < 12; k++) begin
            cyc(25'hB00000, 5'b01011, 5'b01011, 5'b01011, 5'h1F);
            if (k >= 1) begin
                if (k % 2 == 1)
                    expect_ev(25'(1) << (20 + owners[(k-1)/2]), 5'h10,
                              5'(1) << owners[(k-1)/2]);
                else
                    expect_ev('0, '0, '0);
            end
        end
        cyc('0, '0, '0, '0, 5'h1F);
        expect_ev('0, '0, '0);

        // Packet lock with backpressure: input 1 (4 flits) vs input 0 on output 2
        cyc(25'h800, 5'b00010, 5'b00010, 5'b00000, 5'h1F);
        cyc(25'hC00, 5'b00011, 5'b00011, 5'b00001, 5'h1F);
        expect_ev(25'h800, 5'h04, 5'h02);
        cyc(25'hC00, 5'b00011, 5'b00001, 5'b00001, 5'h1F);
        expect_ev(25'h800, 5'h04, 5'h02);
        cyc(25'hC00, 5'b00011, 5'b00001, 5'b00001, 5'b11011);
        cyc(25'hC00, 5'b00011, 5'b00001, 5'b00001, 5'b11011);
        expect_ev(25'h800, 5'h04, 5'h00);
        cyc(25'hC00, 5'b00011, 5'b00001, 5'b00001, 5'b11011);
        cyc(25'hC00, 5'b00011, 5'b00001, 5'b00001, 5'h1F);
        expect_ev(25'h800, 5'h04, 5'h02);
        cyc(25'hC00, 5'b00011, 5'b00001, 5'b00011, 5'h1F);
        expect_ev(25'h800, 5'h04, 5'h02);
        cyc(25'h400, 5'b00001, 5'b00001, 5'b00001, 5'h1F);
        expect_ev('0, '0, '0);
        cyc(25'h400, 5'b00001, 5'b00001, 5'b00001, 5'h1F);
        expect_ev(25'h400, 5'h04, 5'h01);
        cyc('0, '0, '0, '0, 5'h1F);
        expect_ev('0, '0, '0);

        // Parallel outputs with a multi-hot request from input 0
        cyc(25'h88020, 5'b10001, 5'b10001, 5'b10001, 5'h1F);
        cyc(25'h88020, 5'b10001, 5'b10001, 5'b10001, 5'h1F);
        expect_ev(25'h80020, 5'h0A, 5'h11);
        cyc('0, '0, '0, '0, 5'h1F);
        expect_ev('0, '0, '0);

        // Reset while output 3 is locked mid-packet
        cyc(25'h20000, 5'b00100, 5'b00100, 5'b00000, 5'h1F);
        cyc(25'h20000, 5'b00100, 5'b00100, 5'b00000, 5'h1F);
        expect_ev(25'h20000, 5'h08, 5'h04);
        cyc(25'h20000, 5'b00100, 5'b00000, 5'b00000, 5'h1F);
        expect_ev(25'h20000, 5'h08, 5'h04);
        cyc('0, '0, '0, '0, 5'h1F);
        rst = 1'b0;
        cyc(25'h80000, 5'b10000, 5'b10000, 5'b10000, 5'h1F);
        rst = 1'b1;
        expect_ev('0, '0, '0);
        cyc(25'h80000, 5'b10000, 5'b10000, 5'b10000, 5'h1F);
        expect_ev(25'h80000, 5'h08, 5'h10);
        cyc('0, '0, '0, '0, 5'h1F);
        expect_ev('0, '0, '0);

        cyc('0, '0, '0, '0, 5'h1F);
        cyc('0, '0, '0, '0, 5'h1F);
        @(posedge clk);
        chk("pending_events", 32'(q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
